seq_shifter: RTL
================

# seq_shifter

Multi-cycle parametrised shifter for the RISC-V datapath. It takes a WIDTH-bit operand and a shift amount and produces the SLL, SRL or SRA result, shifting STEP bit positions per clock. It is the iterative replacement for the fixed shift-left-by-1 helper. It serves the ALU shift instructions and PC/immediate scaling where a multi-bit shift is needed without a full barrel shifter.

## Interface
- WIDTH, 32, operand/result width. Must be a power of two, ≥ 2.
- STEP, 1, maximum bit positions shifted per cycle. Allowed values are 1, 2, 4 and 8, and STEP ≤ WIDTH.
- SHW (localparam), $clog2(WIDTH), shift-amount width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request. Sampled only in IDLE.
- op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
- data_in  input  WIDTH  operand. Latched when start is accepted.
- shamt  input  SHW  shift amount, 0..WIDTH-1. Latched when start is accepted.
- busy  output  1  high from the edge that accepts start until the edge that raises done.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH  final shifted value. Registered, and held until the next completion.

## Operation
- Registers:
  - work: WIDTH bits.
  - rem: SHW bits.
  - op_q: 2 bits.
  - result.
  - FSM.
- FSM states are IDLE and SHIFT.
- IDLE:
  - If start=1, the next edge does the following: work←data_in, rem←shamt, op_q←op, busy←1, and the state goes to SHIFT.
  - If start=0, nothing changes.
- SHIFT with rem≠0, per edge:
  - Let s = min(STEP, rem).
  - work is shifted by s:
    - SLL: zero fill.
    - SRL: zero fill.
    - SRA: fill with work[WIDTH-1].
    - ROL: bits rotate left.
  - rem←rem−s.
- SHIFT with rem=0, next edge:
  - result←work, done←1, busy←0, and the state goes to IDLE.
- done is high for exactly one cycle and is cleared on the following edge.
- start is ignored while busy=1 (state SHIFT). It is not queued.
- start may be asserted in the cycle done is high. The FSM is then in IDLE, so the request is accepted on that edge (back-to-back operation).
- Arithmetic rules:
  - shamt is unsigned and uses only SHW bits.
  - SRA sign is taken from data_in[WIDTH-1] as latched.
  - No overflow or carry out is reported.
- Reset values: busy=0, done=0, result=0, work=0, rem=0, op_q=0, state IDLE.
- Reset mid-operation aborts the operation. No done is produced, and result returns to 0.

## Timing
- Let k = ceil(shamt/STEP).
- done rises k+1 edges after the edge that accepts start.
  - shamt=0 gives 1 edge of latency.
  - WIDTH=32, STEP=1, shamt=31 gives 32 edges.
- busy is high for exactly k+1 cycles.
- result changes only on the edge that raises done, and is valid from that cycle onward.
- Maximum throughput is one operation per k+1 cycles. There are no idle bubbles when start is held high.
- data_in, shamt and op may change freely after the accepting edge.

## Configuration
- SEQ_SHIFTER_ROTATE_EN defined: op=11 performs a rotate-left, with bits leaving the MSB re-entering at the LSB, at the same latency as the other ops.
- SEQ_SHIFTER_ROTATE_EN undefined: op=11 is decoded as SLL. The rotate path is not synthesised.

## Test plan
- WIDTH=32, STEP=1, SLL, data_in=0x0000_0001, shamt=31 → done after 32 edges, result=0x8000_0000, busy high for 32 cycles.
- WIDTH=32, STEP=1:
  - SRA 0x8000_00F0 by 4 → result=0xF800_000F.
  - SRL of the same operand → result=0x0800_000F.
  - Each completes after 5 edges.
- shamt=0 with op=SRA and data_in=0x1234_5678 → done after 1 edge, result=0x1234_5678. Then with start held high, a second request is accepted in the done cycle with no gap.
- STEP=4, SLL 0x0000_0003 by 9 → 3 shift cycles, done after 4 edges, result=0x0000_0600. A start pulse with different operands during busy is ignored and the result is unchanged.
- rst asserted 3 edges into a 20-cycle operation → busy=0, done never pulses, result=0. A new request after reset completes normally.
- With SEQ_SHIFTER_ROTATE_EN, op=11, 0x8000_0001, shamt=1 → result=0x0000_0003. Without the macro, the same stimulus → result=0x0000_0002.

Source files
------------

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Purpose:
//   Iterative shifter for the RISC-V datapath. Latches a WIDTH-bit operand and
//   a shift amount on start, then shifts the working value by up to STEP bit
//   positions per clock. It produces SLL, SRL or SRA, and optionally ROL.
//   The final value is written to result on the same edge that raises the
//   one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 2)
//   STEP   maximum bit positions shifted per cycle (1, 2, 4 or 8; <= WIDTH)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   start    in   request, sampled only in IDLE
//   op       in   00 SLL, 01 SRL, 10 SRA, 11 ROL (or SLL, see below)
//   data_in  in   operand, latched when start is accepted
//   shamt    in   shift amount (SHW bits), latched when start is accepted
//   busy     out  high from the accepting edge until the edge raising done
//   done     out  one-cycle completion pulse
//   result   out  registered shifted value, held until the next completion
//
// Configuration macro:
//   SEQ_SHIFTER_ROTATE_EN  when defined, op=11 is rotate-left; when undefined,
//                          op=11 decodes as SLL and no rotate logic is built.
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);

    localparam int SHW = $clog2(WIDTH);

    // One extra bit so that STEP == WIDTH is still representable.
    localparam logic [SHW:0] L_STEP  = (SHW+1)'(STEP);
    localparam logic [SHW:0] L_WIDTH = (SHW+1)'(WIDTH);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic             r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_rem;
    logic [1:0]       r_op;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    logic [SHW:0]     w_rem_ext;
    logic [SHW:0]     w_s;
    logic [WIDTH-1:0] w_next;

    // Step size for this cycle: min(STEP, rem)
    always_comb begin
        w_rem_ext = {1'b0, r_rem};
        if (w_rem_ext < L_STEP) begin
            w_s = w_rem_ext;
        end else begin
            w_s = L_STEP;
        end
    end

    // Next working value: shift r_work by w_s according to the latched op
    always_comb begin
        w_next = r_work;
        case (r_op)
            OP_SLL:  w_next = r_work << w_s;
            OP_SRL:  w_next = r_work >> w_s;
            // Sign fill comes from the current MSB, which is the latched data_in sign.
            OP_SRA:  w_next = WIDTH'($signed(r_work) >>> w_s);
`ifdef SEQ_SHIFTER_ROTATE_EN
            // w_s is never 0 when this value is used, so the right shift stays < WIDTH.
            OP_ROL:  w_next = (r_work << w_s) | (r_work >> (L_WIDTH - w_s));
`else
            OP_ROL:  w_next = r_work << w_s;
`endif
            default: w_next = r_work << w_s;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_work   <= {WIDTH{1'b0}};
            r_rem    <= {SHW{1'b0}};
            r_op     <= 2'b00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_work  <= data_in;
                        r_rem   <= shamt;
                        r_op    <= op;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (r_rem != {SHW{1'b0}}) begin
                        r_work <= w_next;
                        r_rem  <= r_rem - w_s[SHW-1:0];
                    end else begin
                        r_result <= r_work;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
